// File: rtl/serial_sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // Counter must be able to represent WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell and a registered borrow.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
//
// state | meaning
// IDLE  | waiting for start; diff/borrow hold the last result
// SHIFT | one operand bit per cycle through the cell, busy=1
// DONE  | result copied to diff/borrow, done pulses for one cycle
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  sub_state_t       state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             d;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             msb_a;
  logic             msb_b;
`endif

  full_subtractor u_cell (
    .a    (opa[0]),
    .b    (opb[0]),
    .bin  (bin),
    .d    (d),
    .bout (bout)
  );

  // Result enters from the MSB side so that after WIDTH shifts bit 0 sits at bit 0.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = d;
    end else begin : g_res_wn
      assign res_next = {d, res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      res    <= '0;
      bin    <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
      msb_a  <= 1'b0;
      msb_b  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= b;
            res   <= '0;
            bin   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            msb_a <= a[WIDTH-1];
            msb_b <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          res <= res_next;
          opa <= opa >> 1;
          opb <= opb >> 1;
          bin <= bout;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            diff   <= res_next;
            borrow <= bout;
`ifdef SERIAL_SUB_OVF_EN
            // d is the result MSB on the final bit cycle.
            ovf    <= (msb_a ^ msb_b) & (d ^ msb_a);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial subtractor: computes `diff = a - b` on WIDTH-bit unsigned operands, one bit per clock, LSB first, through a single one-bit full-subtractor cell with a registered borrow. It is the sequential successor of the combinational half-subtractor cell in the arithmetic-circuits set. Use it where area matters more than latency. A start/busy/done handshake lets a controller launch an operation and collect the result.

## Interface
- `WIDTH`, default 8, operand and result width in bits; legal range 1 to 64.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  WIDTH  minuend; sampled on the accepting edge only.
- `b`  in  WIDTH  subtrahend; sampled on the accepting edge only.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse when the result becomes valid.
- `diff`  out  WIDTH  result, `a - b` mod 2^WIDTH.
- `borrow`  out  1  final borrow out, 1 when a < b unsigned.
- `ovf`  out  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- States: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on `start`.
  - SHIFT -> DONE after WIDTH bit cycles.
  - DONE -> IDLE unconditionally.
- Accept, in IDLE with `start=1`:
  - load `a` and `b` into shift registers;
  - clear the borrow flop;
  - clear the bit counter to 0.
- Each SHIFT cycle, the cell computes on the current LSBs `ai`, `bi` and the borrow flop `bin`:
  - `d = ai ^ bi ^ bin`;
  - `bout = (~ai & bi) | (~(ai ^ bi) & bin)`.
- At the end of each SHIFT cycle:
  - `d` shifts into the result register from the MSB side;
  - the operand registers shift right;
  - the borrow flop takes `bout`;
  - the counter increments.
- The counter width is `$clog2(WIDTH+1)`. SHIFT exits when the counter reaches WIDTH-1 on the current cycle.
- `diff` and `borrow` hold their last values from DONE until the next accept. They do not change during a later SHIFT: the result register is internal and copied to `diff` on entry to DONE.
- `start` while in SHIFT or DONE is ignored and is not queued.
- `a` and `b` changing after the accepting edge have no effect.

## Timing
- Reset values: state IDLE, `busy=0`, `done=0`, `diff=0`, `borrow=0`, `ovf=0`, counter 0.
- Reset asserted mid-operation aborts within one edge. There is no `done` pulse for the aborted operation.
- `rst` has priority over `start` on the same edge.
- Accept at edge E0:
  - `busy=1` for cycles E0+1 .. E0+WIDTH;
  - `done=1` and the result is valid in cycle E0+WIDTH+1;
  - `busy=0` during DONE.
- Latency from start to done is WIDTH+1 cycles. Throughput is one operation per WIDTH+2 cycles.
- The earliest next accept is the edge that ends the IDLE cycle following DONE.
- WIDTH=1: one SHIFT cycle. Results equal the half-subtractor truth table because the initial borrow is 0.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- Defined:
  - port `ovf` exists;
  - in DONE it is `(a[MSB] != b[MSB]) & (diff[MSB] != a[MSB])`, using the registered operand MSBs captured at accept;
  - it holds with `diff`; its reset value is 0.
- Undefined: no `ovf` port, no MSB capture flops. All other behaviour is identical.

## Structure
- Package `serial_sub_pkg` holds:
  - the state enum `sub_state_t` (IDLE, SHIFT, DONE);
  - a function returning counter width for a given WIDTH.
- Sub-module `full_subtractor`: purely combinational one-bit cell, ports `a`, `b`, `bin`, `d`, `bout`. It is instantiated once.
- The top module holds the FSM, shift registers, counter and borrow flop.

## Test plan
All scenarios use WIDTH=8 unless stated.
- `a=0x5A`, `b=0x1B`, start -> `done` exactly 9 cycles later with `diff=0x3F`, `borrow=0`; `busy` high for exactly 8 cycles.
- `a=0x00`, `b=0x01` -> `diff=0xFF`, `borrow=1`. With SERIAL_SUB_OVF_EN, `ovf=0`.
- `a=0x80`, `b=0x01` -> `diff=0x7F`, `borrow=0`; with the macro, `ovf=1`. Then `a=0x01`, `b=0x02` -> `diff=0xFF`, `borrow=1`, `ovf=0`.
- Start `0x10 - 0x01`; pulse `start` with `0xFF - 0x00` in SHIFT cycle 3 -> single `done`, `diff=0x0F`; the second request is not executed.
- Start `0xAA - 0x55`; assert `rst` in SHIFT cycle 4 -> next cycle IDLE, all outputs 0, no `done`. A fresh start then yields `diff=0x55`, `borrow=0`.
- WIDTH=1: all four `a`/`b` combinations -> (diff, borrow) = 00:(0,0), 01:(1,1), 10:(1,0), 11:(0,0), each with `done` 2 cycles after start.
